// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b) built from one full-subtractor cell
// and a borrow flip-flop; one bit per clock, single-cycle done strobe at the end.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;

  logic a_bit, b_bit, d_bit, bout_bit;

  // Full-subtractor cell on the current LSBs.
  assign a_bit    = a_sr_q[0];
  assign b_bit    = b_sr_q[0];
  assign d_bit    = a_bit ^ b_bit ^ bin_q;
  assign bout_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StShift;
          a_sr_d  = a_i;
          b_sr_d  = b_i;
          bin_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        bin_d  = bout_bit;
        cnt_d  = cnt_q + 1'b1;
        // Borrow output only moves on the final bit so it holds between ops.
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          borrow_d = bout_bit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy_o   = (state_q == StShift);
  assign done_o   = (state_q == StDone);
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected {borrow, diff} and start edge are
// queued at each accepted start and popped by a monitor whenever done is seen.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W:0] exp;
    int         sedge;
  } sb_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, done_o, borrow_o;
  logic [W-1:0] diff_o;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  logic prev_done = 1'b0;
  sb_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .diff_o  (diff_o),
    .borrow_o(borrow_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare each done against the oldest pending expectation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) begin
        check_eq("done_width", {31'd0, prev_done}, 32'd0);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          check_eq("diff", {24'd0, diff_o}, {24'd0, e.exp[W-1:0]});
          check_eq("borrow", {31'd0, borrow_o}, {31'd0, e.exp[W]});
          check_eq("latency", cyc - e.sedge, W);
        end else begin
          check_eq("sb_pending", sb.size(), 1);
        end
      end
      prev_done <= done_o;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Called at a negedge with the DUT idle or in its done cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    sb_t e;
    logic [W-1:0] d;
    d       = a - b;
    e.exp   = {(a < b), d};
    e.sedge = cyc + 1;
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic wait_done();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      found = done_o;
    end
    check_eq("done_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] corners [6];
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFE; corners[5] = 8'hFF;

    rst_i   = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_diff", {24'd0, diff_o}, 32'd0);
    check_eq("rst_borrow", {31'd0, borrow_o}, 32'd0);
    rst_i = 1'b0;

    // Basic op with busy-window check.
    @(negedge clk_i);
    issue(8'h5A, 8'h23);
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk_i);
      check_eq("busy_window", {31'd0, busy_o}, 32'd1);
      check_eq("no_early_done", {31'd0, done_o}, 32'd0);
    end
    wait_done();
    check_eq("busy_at_done", {31'd0, busy_o}, 32'd0);

    // Result must hold while idle.
    repeat (3) @(negedge clk_i);
    check_eq("hold_diff", {24'd0, diff_o}, 32'h37);
    check_eq("hold_borrow", {31'd0, borrow_o}, 32'd0);

    // Directed cases, back-to-back.
    issue(8'h23, 8'h5A); wait_done();
    issue(8'h00, 8'h01); wait_done();
    issue(8'hFF, 8'hFF); wait_done();

    // Start during busy cycle 3 must be ignored.
    @(negedge clk_i);
    issue(8'h10, 8'h01);
    repeat (2) @(negedge clk_i);
    start_i = 1'b1;
    a_i     = 8'h00;
    b_i     = 8'hFF;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done();

    // Start in the done cycle is accepted; previous result is checked by the monitor there.
    issue(8'h80, 8'h7F); wait_done();

    // Reset mid-operation discards the result.
    @(negedge clk_i);
    issue(8'h33, 8'h44);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("midrst_done", {31'd0, done_o}, 32'd0);
    check_eq("midrst_diff", {24'd0, diff_o}, 32'd0);
    check_eq("midrst_borrow", {31'd0, borrow_o}, 32'd0);
    repeat (12) begin
      @(negedge clk_i);
      check_eq("no_done_after_rst", {31'd0, done_o}, 32'd0);
    end
    issue(8'hC8, 8'h64); wait_done();

    // Corner cross product.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        issue(corners[i], corners[j]);
        wait_done();
      end
    end

    // Random sweep with occasional idle gaps.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk_i);
      issue(W'($urandom), W'($urandom));
      wait_done();
    end

    repeat (3) @(negedge clk_i);
    check_eq("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
